// File: rtl/peripheral_spram_axi4_slave.sv
// AXI4 responder in front of a single-port 32-bit word RAM.
// Handles one transaction at a time. A write wins when AW and AR arrive together.
module peripheral_spram_axi4_slave #(
  parameter int ADDR_WIDTH = 10,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [3:0]  awid,
  input  logic [31:0] awadr,
  input  logic [3:0]  awlen,
  input  logic [1:0]  awburst,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wrdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [3:0]  arlen,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready
);

  typedef enum logic [2:0] {IDLE, WDATA, WRESP, RREAD, RDATA} state_t;

  state_t                  r_state, w_state_next;
  logic                    r_ready;
  logic [3:0]              r_id;
  logic [ADDR_WIDTH-1:0]   r_idx;
  logic [3:0]              r_len;
  logic [1:0]              r_burst;
  logic [3:0]              r_beat;
  logic                    r_err;
  logic [31:0]             r_rdata;
  logic [31:0]             r_mem [MEM_DEPTH];

  logic                    w_last;
  logic                    w_aw_hs;
  logic                    w_ar_hs;
  logic                    w_we;
  logic                    w_re;
  logic [ADDR_WIDTH-1:0]   w_idx_next;
  logic [ADDR_WIDTH-1:0]   w_raddr;
  logic                    w_unused;

  function automatic logic [ADDR_WIDTH-1:0] f_wrap(input logic [ADDR_WIDTH:0] v);
    logic [31:0] m;
    m = 32'(v) % 32'(MEM_DEPTH);
    return m[ADDR_WIDTH-1:0];
  endfunction

  assign w_last     = (r_beat == r_len);
  assign w_aw_hs    = (r_state == IDLE) && r_ready && awvalid;
  assign w_ar_hs    = (r_state == IDLE) && r_ready && arvalid && !awvalid;
  assign w_idx_next = f_wrap({1'b0, r_idx} + (ADDR_WIDTH + 1)'(1));
  assign w_we       = (r_state == WDATA) && wvalid && !r_burst[1];
  // Prefetch the next beat on each accepted read beat so bursts stream one per cycle.
  assign w_re       = (r_state == RREAD) || ((r_state == RDATA) && rready && !w_last);
  assign w_raddr    = (r_state == RDATA) ? w_idx_next : r_idx;
  assign w_unused   = ^{awadr[31:ADDR_WIDTH+2], awadr[1:0], araddr[31:ADDR_WIDTH+2],
                        araddr[1:0]};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_aw_hs)      w_state_next = WDATA;
        else if (w_ar_hs) w_state_next = RREAD;
      end
      WDATA:   if (wvalid && w_last) w_state_next = WRESP;
      WRESP:   if (bready) w_state_next = IDLE;
      RREAD:   w_state_next = RDATA;
      RDATA:   if (rready && w_last) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    awready = (r_state == IDLE) && r_ready;
    arready = (r_state == IDLE) && r_ready && !awvalid;
    wready  = (r_state == WDATA);
    bvalid  = (r_state == WRESP);
    bid     = (r_state == WRESP) ? r_id : 4'd0;
    bresp   = (r_state == WRESP) ? {r_err, 1'b0} : 2'b00;
    rvalid  = (r_state == RDATA);
    rid     = (r_state == RDATA) ? r_id : 4'd0;
    rdata   = (r_state == RDATA) ? r_rdata : 32'd0;
    rlast   = (r_state == RDATA) && w_last;
    rresp   = 2'b00;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_ready <= 1'b0;
      r_id    <= '0;
      r_idx   <= '0;
      r_len   <= '0;
      r_burst <= '0;
      r_beat  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_ready <= 1'b1;
      if (w_aw_hs) begin
        r_id    <= awid;
        r_idx   <= f_wrap({1'b0, awadr[ADDR_WIDTH+1:2]});
        r_len   <= awlen;
        r_burst <= awburst;
        r_beat  <= '0;
        r_err   <= awburst[1];
      end else if (w_ar_hs) begin
        r_id    <= arid;
        r_idx   <= f_wrap({1'b0, araddr[ADDR_WIDTH+1:2]});
        r_len   <= arlen;
        r_beat  <= '0;
      end else if ((r_state == WDATA) && wvalid) begin
        r_beat <= r_beat + 4'd1;
        if (r_burst == 2'b01) r_idx <= w_idx_next;
        if (wlast != w_last) r_err <= 1'b1;
      end else if ((r_state == RDATA) && rready) begin
        r_beat <= r_beat + 4'd1;
        r_idx  <= w_idx_next;
      end
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge aclk) begin
    if (w_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) r_mem[r_idx][8*b +: 8] <= wrdata[8*b +: 8];
      end
    end
    if (w_re) r_rdata <= r_mem[w_raddr];
  end

endmodule
